rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux.sv | 95 +++++++++
 tb/tb_rr_arb_mux.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// Round-robin / fixed-priority N:1 arbiter feeding a single registered output stage.
// Downstream backpressure stalls arbitration; the output word holds until accepted.
module rr_arb_mux #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NCH   = 5,
  localparam int unsigned SELW = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_mode,
  input  logic [NCH-1:0]         io_in_valid,
  output logic [NCH-1:0]         io_in_ready,
  input  logic [NCH*WIDTH-1:0]   io_in_bits,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [WIDTH-1:0]       io_out_bits,
  output logic [SELW-1:0]        io_out_sel
);

  logic            load_en;
  logic            any_valid;
  logic            xfer;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] grant;
  logic [SELW-1:0] low_idx;
  logic [SELW-1:0] hi_idx;
  logic            found_lo;
  logic            found_hi;
  logic [WIDTH-1:0] grant_bits;

  // Lowest valid index overall, and lowest valid index strictly above ptr.
  // Round-robin takes the latter when present, otherwise wraps to the former.
  always_comb begin
    found_lo = 1'b0;
    found_hi = 1'b0;
    low_idx  = '0;
    hi_idx   = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (io_in_valid[i]) begin
        if (!found_lo) begin
          low_idx  = SELW'(i);
          found_lo = 1'b1;
        end
        if (!found_hi && (SELW'(i) > ptr)) begin
          hi_idx   = SELW'(i);
          found_hi = 1'b1;
        end
      end
    end
  end

  always_comb begin
    any_valid = found_lo;
    grant     = (io_mode || !found_hi) ? low_idx : hi_idx;
    load_en   = !io_out_valid || io_out_ready;
    xfer      = !reset && load_en && any_valid;
  end

  // One-hot ready on the granted channel only.
  always_comb begin
    io_in_ready = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      io_in_ready[i] = xfer && (grant == SELW'(i));
    end
  end

  always_comb begin
    grant_bits = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (grant == SELW'(i)) begin
        grant_bits = io_in_bits[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage and round-robin pointer; ptr resets to the last channel so channel 0 goes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_out_valid <= 1'b0;
      io_out_bits  <= '0;
      io_out_sel   <= '0;
      ptr          <= SELW'(NCH - 1);
    end else if (load_en) begin
      if (any_valid) begin
        io_out_valid <= 1'b1;
        io_out_bits  <= grant_bits;
        io_out_sel   <= grant;
        ptr          <= grant;
      end else begin
        io_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus randomized traffic,
// all checked against an arithmetic reference model of the arbitration rules.
module tb_rr_arb_mux;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned NCH   = 5;
  localparam int unsigned SELW  = 3;

  logic                 clk;
  logic                 reset;
  logic                 io_mode;
  logic [NCH-1:0]       io_in_valid;
  logic [NCH-1:0]       io_in_ready;
  logic [NCH*WIDTH-1:0] io_in_bits;
  logic                 io_out_valid;
  logic                 io_out_ready;
  logic [WIDTH-1:0]     io_out_bits;
  logic [SELW-1:0]      io_out_sel;

  rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_mode      (io_mode),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_out_sel   (io_out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int               m_ptr;
  logic             m_valid;
  logic [WIDTH-1:0] m_bits;
  int               m_sel;

  function automatic int model_grant();
    if (io_mode) begin
      for (int i = 0; i < int'(NCH); i++) if (io_in_valid[i]) return i;
    end else begin
      for (int k = 1; k <= int'(NCH); k++) begin
        int idx;
        idx = (m_ptr + k) % int'(NCH);
        if (io_in_valid[idx]) return idx;
      end
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] model_ready();
    int g;
    logic [NCH-1:0] r;
    r = '0;
    g = model_grant();
    if (!reset && (!m_valid || io_out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    int g;
    g = model_grant();
    if (reset) begin
      m_valid = 1'b0;
      m_bits  = '0;
      m_sel   = 0;
      m_ptr   = int'(NCH) - 1;
    end else if (!m_valid || io_out_ready) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_bits  = io_in_bits[g*WIDTH +: WIDTH];
        m_sel   = g;
        m_ptr   = g;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic set_bits_seq();
    for (int i = 0; i < int'(NCH); i++) io_in_bits[i*WIDTH +: WIDTH] = WIDTH'(16'h1000 + i);
  endtask

  task automatic set_bits_rand();
    for (int i = 0; i < int'(NCH); i++) io_in_bits[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      io_in_valid  = NCH'($urandom);
      io_out_ready = 1'(c);
      io_mode      = 1'($urandom);
      set_bits_rand();
      #1;
      n_checks++;
      if (io_in_ready !== '0) $display("FAIL reset_ready c=%0d got=%b exp=0", c, io_in_ready);
      else n_pass++;
      model_clock();
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (io_out_valid !== 1'b0 || io_out_bits !== '0 || io_out_sel !== '0)
        $display("FAIL reset_out c=%0d got v=%b b=%h s=%0d exp v=0 b=0 s=0", c, io_out_valid, io_out_bits, io_out_sel);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic test_rr_sequence();
    io_mode = 1'b0; io_out_ready = 1'b1; io_in_valid = '1;
    set_bits_seq();
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (io_in_ready !== model_ready()) $display("FAIL rr_ready c=%0d got=%b exp=%b", c, io_in_ready, model_ready());
      else n_pass++;
      model_clock();
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (io_out_valid !== 1'b1 || io_out_sel !== SELW'(c % 5) || io_out_bits !== WIDTH'(16'h1000 + c % 5))
        $display("FAIL rr_seq c=%0d got v=%b s=%0d b=%h exp v=1 s=%0d b=%h", c, io_out_valid, io_out_sel, io_out_bits, c % 5, 16'h1000 + c % 5);
      else n_pass++;
    end
  endtask

  task automatic test_fixed();
    int exp_sel;
    io_mode = 1'b1; io_out_ready = 1'b1; io_in_valid = '1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) io_in_valid = 5'b11110;
      exp_sel = (c == 3) ? 1 : 0;
      model_clock();
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (io_out_valid !== 1'b1 || io_out_sel !== SELW'(exp_sel) || io_out_sel !== SELW'(m_sel))
        $display("FAIL fixed_sel c=%0d got=%0d exp=%0d", c, io_out_sel, exp_sel);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int exp_seq [4] = '{3, 1, 3, 1};
    io_mode = 1'b0; io_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      io_in_valid = (c == 0) ? 5'b01000 : 5'b01010;
      #1;
      n_checks++;
      if (io_in_ready !== NCH'(1 << exp_seq[c])) $display("FAIL wrap_ready c=%0d got=%b exp=%b", c, io_in_ready, NCH'(1 << exp_seq[c]));
      else n_pass++;
      model_clock();
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (io_out_sel !== SELW'(exp_seq[c])) $display("FAIL wrap_sel c=%0d got=%0d exp=%0d", c, io_out_sel, exp_seq[c]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] held_bits;
    int held_sel;
    held_bits = m_bits; held_sel = m_sel;
    io_out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      io_in_valid = NCH'($urandom);
      io_mode     = 1'($urandom);
      set_bits_rand();
      #1;
      n_checks++;
      if (io_in_ready !== '0) $display("FAIL stall_ready c=%0d got=%b exp=0", c, io_in_ready);
      else n_pass++;
      model_clock();
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (io_out_valid !== 1'b1 || io_out_bits !== held_bits || io_out_sel !== SELW'(held_sel))
        $display("FAIL stall_hold c=%0d got v=%b b=%h s=%0d exp v=1 b=%h s=%0d", c, io_out_valid, io_out_bits, io_out_sel, held_bits, held_sel);
      else n_pass++;
    end
    // Release: ptr held at 1, so round-robin continues at channel 2.
    io_out_ready = 1'b1; io_mode = 1'b0; io_in_valid = '1;
    #1;
    model_clock();
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (io_out_sel !== SELW'(2) || io_out_bits !== m_bits) $display("FAIL stall_release got s=%0d b=%h exp s=2 b=%h", io_out_sel, io_out_bits, m_bits);
    else n_pass++;
  endtask

  task automatic test_drain();
    logic [WIDTH-1:0] last_bits;
    last_bits = m_bits;
    io_in_valid = '0; io_out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      model_clock();
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (io_out_valid !== 1'b0 || io_out_bits !== last_bits || io_out_sel !== SELW'(2))
        $display("FAIL drain c=%0d got v=%b b=%h s=%0d exp v=0 b=%h s=2", c, io_out_valid, io_out_bits, io_out_sel, last_bits);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    io_in_valid = 5'b00100; io_mode = 1'b0; io_out_ready = 1'b1;
    model_clock();
    @(posedge clk); @(negedge clk);
    io_out_ready = 1'b0; io_in_valid = '1;
    model_clock();
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (io_in_ready !== '0) $display("FAIL rstmid_ready got=%b exp=0", io_in_ready);
    else n_pass++;
    model_clock();
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (io_out_valid !== 1'b0 || io_out_sel !== '0 || io_out_bits !== '0)
      $display("FAIL rstmid_out got v=%b s=%0d b=%h exp v=0 s=0 b=0", io_out_valid, io_out_sel, io_out_bits);
    else n_pass++;
    reset = 1'b0; io_out_ready = 1'b1; io_in_valid = '1;
    model_clock();
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (io_out_valid !== 1'b1 || io_out_sel !== '0) $display("FAIL rstmid_first got v=%b s=%0d exp v=1 s=0", io_out_valid, io_out_sel);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      reset        = ($urandom_range(0, 99) < 2);
      io_out_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 9) == 0) io_mode = ~io_mode;
      io_in_valid  = NCH'($urandom);
      set_bits_rand();
      #1;
      n_checks++;
      if (io_in_ready !== model_ready()) $display("FAIL rand_ready c=%0d got=%b exp=%b", c, io_in_ready, model_ready());
      else n_pass++;
      model_clock();
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (io_out_valid !== m_valid || io_out_bits !== m_bits || io_out_sel !== SELW'(m_sel))
        $display("FAIL rand_out c=%0d got v=%b b=%h s=%0d exp v=%b b=%h s=%0d", c, io_out_valid, io_out_bits, io_out_sel, m_valid, m_bits, m_sel);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; io_mode = 1'b0; io_in_valid = '0; io_out_ready = 1'b0; io_in_bits = '0;
    m_ptr = int'(NCH) - 1; m_valid = 1'b0; m_bits = '0; m_sel = 0;
    @(negedge clk);
    test_reset();
    test_rr_sequence();
    test_fixed();
    test_wrap();
    test_stall();
    test_drain();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
